// File: rtl/al_flash_reader.sv
// Auto-load flash reader: each EXECUTE reads one config record from parallel
// flash and replays its words as register writes. Define AL_CHKSUM_EN for record checksums.
module al_flash_reader #(
  parameter int          WORDS_PER_ADDR = 4,
  parameter int          RD_WAIT        = 7,
  parameter logic [22:0] BASE_ADDR      = 23'h7E0000,
  parameter logic [5:0]  LAST_ADDR      = 6'd33
) (
  input  logic        CLK,
  input  logic        RST_B,
  input  logic        EXECUTE,
  input  logic [5:0]  ADDR,
  input  logic        AL_ENA,
  input  logic        CLR_AL_DONE,
  output logic        BUSY,
  output logic        AL_DONE,
  output logic        CHK_ERR,
  output logic [22:0] FLASH_A,
  output logic        FLASH_CE_B,
  output logic        FLASH_OE_B,
  input  logic [15:0] FLASH_DQ,
  output logic [7:0]  WR_ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WAIT, S_CAPT, S_FIN} state_t;

  localparam logic [1:0] IDX_LAST = 2'(WORDS_PER_ADDR - 1);

  state_t      state_q, state_d;
  logic [5:0]  addr_q, addr_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        al_done_q, al_done_d;
  logic [22:0] flash_a_q, flash_a_d;
  logic        ce_b_q, ce_b_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        wr_stb_q, wr_stb_d;

  logic accept, last_idx, blank, strobe_ok, chk_fail;

  function automatic logic [22:0] word_addr(input logic [5:0] a, input logic [1:0] i);
    return BASE_ADDR + 23'(a) * 23'(WORDS_PER_ADDR) + 23'(i);
  endfunction

  assign accept   = (state_q == S_IDLE) && EXECUTE && AL_ENA;
  assign last_idx = (idx_q == IDX_LAST);
  assign blank    = (idx_q == 2'd0) && (FLASH_DQ == 16'hFFFF);

`ifdef AL_CHKSUM_EN
  // Last word carries the sum of the others; it is checked, never written out.
  logic [15:0] sum_q, sum_d;
  logic        chk_err_q, chk_err_d;

  assign strobe_ok = !last_idx;
  assign chk_fail  = last_idx && (FLASH_DQ != sum_q);

  always_comb begin
    sum_d     = sum_q;
    chk_err_d = CLR_AL_DONE ? 1'b0 : chk_err_q;
    if (accept)
      sum_d = 16'd0;
    else if (state_q == S_CAPT && !last_idx)
      sum_d = sum_q + FLASH_DQ;
    if (state_q == S_CAPT && AL_ENA && !blank && chk_fail)
      chk_err_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      sum_q     <= 16'd0;
      chk_err_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign CHK_ERR = chk_err_q;
`else
  assign strobe_ok = 1'b1;
  assign chk_fail  = 1'b0;
  assign CHK_ERR   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    al_done_d = CLR_AL_DONE ? 1'b0 : al_done_q;
    flash_a_d = flash_a_q;
    ce_b_d    = ce_b_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_stb_d  = 1'b0;

    case (state_q)
      S_IDLE: if (accept) begin
        state_d   = S_SETUP;
        addr_d    = ADDR;
        idx_d     = 2'd0;
        busy_d    = 1'b1;
        ce_b_d    = 1'b0;
        flash_a_d = word_addr(ADDR, 2'd0);
      end
      S_SETUP: begin
        cnt_d   = 8'(RD_WAIT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) state_d = S_CAPT;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_CAPT: begin
        if (blank) begin
          al_done_d = 1'b1;
          ce_b_d    = 1'b1;
          state_d   = S_FIN;
        end else begin
          if (strobe_ok) begin
            wr_stb_d  = 1'b1;
            wr_data_d = FLASH_DQ;
            wr_addr_d = {addr_q, idx_q};
          end
          if (last_idx) begin
            ce_b_d  = 1'b1;
            state_d = S_FIN;
            if (chk_fail) al_done_d = 1'b1;
          end else begin
            idx_d     = idx_q + 2'd1;
            flash_a_d = word_addr(addr_q, idx_q + 2'd1);
            state_d   = S_SETUP;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (addr_q == LAST_ADDR) al_done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort discards whatever this cycle would have produced, done flag included.
    if (state_q != S_IDLE && !AL_ENA) begin
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      ce_b_d    = 1'b1;
      wr_stb_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      al_done_d = CLR_AL_DONE ? 1'b0 : al_done_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      state_q   <= S_IDLE;
      addr_q    <= 6'd0;
      idx_q     <= 2'd0;
      cnt_q     <= 8'd0;
      busy_q    <= 1'b0;
      al_done_q <= 1'b0;
      flash_a_q <= 23'd0;
      ce_b_q    <= 1'b1;
      wr_addr_q <= 8'd0;
      wr_data_q <= 16'd0;
      wr_stb_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      al_done_q <= al_done_d;
      flash_a_q <= flash_a_d;
      ce_b_q    <= ce_b_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_stb_q  <= wr_stb_d;
    end
  end

  assign BUSY       = busy_q;
  assign AL_DONE    = al_done_q;
  assign FLASH_A    = flash_a_q;
  assign FLASH_CE_B = ce_b_q;
  assign FLASH_OE_B = ce_b_q;
  assign WR_ADDR    = wr_addr_q;
  assign WR_DATA    = wr_data_q;
  assign WR_STB     = wr_stb_q;

endmodule

// File: tb/tb_al_flash_reader.sv
// Randomized bench for al_flash_reader against a record-level reference model.
module tb_al_flash_reader;
  localparam int          W    = 4;
  localparam int          RW   = 7;
  localparam int          P    = RW + 2;
  localparam logic [22:0] BASE = 23'h7E0000;
  localparam logic [5:0]  LAST = 6'd33;
`ifdef AL_CHKSUM_EN
  localparam int NSTB = W - 1;
`else
  localparam int NSTB = W;
`endif

  logic        CLK = 1'b0, RST_B = 1'b0, EXECUTE = 1'b0, AL_ENA = 1'b1, CLR_AL_DONE = 1'b0;
  logic [5:0]  ADDR = 6'd0;
  logic        BUSY, AL_DONE, CHK_ERR, FLASH_CE_B, FLASH_OE_B, WR_STB;
  logic [22:0] FLASH_A;
  logic [15:0] FLASH_DQ, WR_DATA;
  logic [7:0]  WR_ADDR;

  logic [15:0] rec [64][4];
  int          n_tot = 0, n_bad = 0;
  bit          m_done = 1'b0, m_err = 1'b0;
  logic [23:0] stb_q [$];
  logic [22:0] fa_q [$];
  logic        prev_ce = 1'b1;
  logic [22:0] prev_a = 23'd0;
  wire  [22:0] f_off = FLASH_A - BASE;

  always #5 CLK = ~CLK;

  al_flash_reader dut (
    .CLK(CLK), .RST_B(RST_B), .EXECUTE(EXECUTE), .ADDR(ADDR), .AL_ENA(AL_ENA),
    .CLR_AL_DONE(CLR_AL_DONE), .BUSY(BUSY), .AL_DONE(AL_DONE), .CHK_ERR(CHK_ERR),
    .FLASH_A(FLASH_A), .FLASH_CE_B(FLASH_CE_B), .FLASH_OE_B(FLASH_OE_B),
    .FLASH_DQ(FLASH_DQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_STB(WR_STB)
  );

  // Flash: 64 records of 4 words at BASE, erased (FFFF) elsewhere.
  assign FLASH_DQ = (f_off < 23'd256) ? rec[f_off[7:2]][f_off[1:0]] : 16'hFFFF;

  always @(negedge CLK) begin
    if (WR_STB) stb_q.push_back({WR_ADDR, WR_DATA});
    if (!FLASH_CE_B && (prev_ce || FLASH_A != prev_a)) fa_q.push_back(FLASH_A);
    prev_ce <= FLASH_CE_B;
    prev_a  <= FLASH_A;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk(tag, {BUSY, AL_DONE, CHK_ERR, FLASH_A, FLASH_CE_B, FLASH_OE_B, WR_ADDR, WR_DATA, WR_STB},
        {3'b000, 23'd0, 2'b11, 8'd0, 16'd0, 1'b0});
  endtask

  task automatic clr_pulse();
    @(posedge CLK); #1 CLR_AL_DONE = 1'b1;
    @(posedge CLK); #1 CLR_AL_DONE = 1'b0;
    m_done = 1'b0; m_err = 1'b0;
    chk("clr_done", AL_DONE, 1'b0);
    chk("clr_err", CHK_ERR, 1'b0);
  endtask

  // One EXECUTE; abort_at / mid_at are busy-cycle numbers (1 = first busy cycle), 0 = none.
  task automatic run_read(input logic [5:0] a, input int abort_at, input int mid_at, input bit clr_hold);
    logic [15:0] d [4];
    logic [23:0] es [$];
    logic [22:0] ea [$];
    bit blank, aborted;
    int len, exp_len, c, nw;
    for (int i = 0; i < 4; i++) d[i] = rec[a][i];
    blank   = (d[0] == 16'hFFFF);
    len     = blank ? P + 1 : W * P + 1;
    aborted = (abort_at > 0) && (abort_at <= len);
    exp_len = aborted ? abort_at : len;
    nw      = blank ? 1 : W;
    for (int i = 0; i < nw; i++)
      if (!aborted || i * P + 1 <= abort_at) ea.push_back(BASE + 23'(a) * 23'(W) + 23'(i));
    if (!blank)
      for (int i = 0; i < NSTB; i++)
        if (!aborted || (i + 1) * P < abort_at) es.push_back({a, 2'(i), d[i]});
    if (clr_hold) begin
      m_done = 1'b0; m_err = 1'b0;
    end else begin
      if (blank && (!aborted || P < abort_at)) m_done = 1'b1;
`ifdef AL_CHKSUM_EN
      if (!blank && d[3] != 16'(d[0] + d[1] + d[2]) && (!aborted || W * P < abort_at)) begin
        m_done = 1'b1; m_err = 1'b1;
      end
`endif
    end
    if (!aborted && a == LAST) m_done = 1'b1;

    stb_q.delete(); fa_q.delete();
    @(posedge CLK); #1 EXECUTE = 1'b1; ADDR = a; CLR_AL_DONE = clr_hold;
    @(posedge CLK); #1 EXECUTE = 1'b0;
    chk("busy_rise", BUSY, 1'b1);
    c = 1;
    while (c < 200) begin
      AL_ENA  = (c != abort_at);
      EXECUTE = (c == mid_at);
      ADDR    = (c == mid_at) ? ~a : a;
      @(posedge CLK); #1;
      if (!BUSY) break;
      c++;
    end
    EXECUTE = 1'b0; AL_ENA = 1'b1;
    chk("busy_timeout", BUSY, 1'b0);
    chk("busy_len", c, exp_len);
    chk("al_done", AL_DONE, m_done);
    chk("chk_err", CHK_ERR, m_err);
    chk("ce_oe_idle", {FLASH_CE_B, FLASH_OE_B}, 2'b11);
    CLR_AL_DONE = 1'b0;
    chk("n_strobe", stb_q.size(), es.size());
    for (int i = 0; i < es.size() && i < stb_q.size(); i++) chk("strobe", stb_q[i], es[i]);
    chk("n_flash_a", fa_q.size(), ea.size());
    for (int i = 0; i < ea.size() && i < fa_q.size(); i++) chk("flash_a", fa_q[i], ea[i]);
  endtask

  initial begin
    for (int r = 0; r < 64; r++)
      for (int i = 0; i < 4; i++) rec[r][i] = 16'h1000 + 16'(r * 4 + i);
    repeat (3) @(posedge CLK);
    #1 chk_rst("reset_init");
    RST_B = 1'b1;

    // Normal read, with a stray EXECUTE mid-read that must be ignored
    run_read(6'd5, 0, 5, 1'b0);
    // Blank record
    rec[9][0] = 16'hFFFF;
    run_read(6'd9, 0, 0, 1'b0);
    clr_pulse();
    // Last record, clear, then clear coinciding with set
    rec[LAST][3] = 16'(rec[LAST][0] + rec[LAST][1] + rec[LAST][2]);
    run_read(LAST, 0, 0, 1'b0);
    chk("last_done", AL_DONE, 1'b1);
    clr_pulse();
    run_read(LAST, 0, 0, 1'b1);
    @(posedge CLK); #1 chk("set_wins", AL_DONE, 1'b1);

    // Reset held 3 cycles in the middle of a read
    @(posedge CLK); #1 EXECUTE = 1'b1; ADDR = 6'd7;
    @(posedge CLK); #1 EXECUTE = 1'b0;
    repeat (12) @(posedge CLK);
    #1 RST_B = 1'b0;
    repeat (3) @(posedge CLK);
    #1 chk_rst("reset_mid");
    RST_B = 1'b1; m_done = 1'b0; m_err = 1'b0;
    @(posedge CLK); #1 chk("busy_after_rst", BUSY, 1'b0);

    // Abort during WAIT of the second word
    run_read(6'd20, P + 4, 0, 1'b0);
    // EXECUTE with AL_ENA low is ignored
    @(posedge CLK); #1 AL_ENA = 1'b0; EXECUTE = 1'b1;
    @(posedge CLK); #1 EXECUTE = 1'b0; AL_ENA = 1'b1;
    chk("exec_no_ena", BUSY, 1'b0);

`ifdef AL_CHKSUM_EN
    rec[12][0] = 16'd1; rec[12][1] = 16'd2; rec[12][2] = 16'd3; rec[12][3] = 16'd6;
    run_read(6'd12, 0, 0, 1'b0);
    rec[12][3] = 16'd7;
    run_read(6'd12, 0, 0, 1'b0);
    clr_pulse();
`endif

    for (int n = 0; n < 24; n++) begin
      logic [5:0] a;
      int kind;
      a    = (n % 6 == 5) ? LAST : 6'($urandom_range(0, 63));
      kind = $urandom_range(0, 9);
      for (int i = 0; i < 4; i++) rec[a][i] = 16'($urandom);
      if (rec[a][0] == 16'hFFFF) rec[a][0] = 16'h0;
`ifdef AL_CHKSUM_EN
      if (kind != 2) rec[a][3] = 16'(rec[a][0] + rec[a][1] + rec[a][2]);
`endif
      if (kind == 0) rec[a][0] = 16'hFFFF;
      run_read(a, (kind == 1 || kind == 3) ? $urandom_range(1, W * P + 1) : 0,
               (kind == 4) ? $urandom_range(1, 30) : 0, 1'b0);
      if (kind >= 7) clr_pulse();
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
